// File: rtl/bist_pkg.sv
// Shared types and default constants for the BIST engine.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE, SEED, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE
  } bist_state_e;

  localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;
  localparam logic [11:0] DEF_MISR_POLY = 12'h829;

endpackage

// File: rtl/bist_engine_if.sv
// Control and CUT-facing signals of the BIST engine; slave is the engine's view.
interface bist_engine_if #(
  parameter int N_CHAINS = 1,
  parameter int N_PI     = 3,
  parameter int N_PO     = 2,
  parameter int MISR_W   = 12,
  parameter int CNT_W    = 7
);
  logic                bist_start;
  logic                bist_abort;
  logic [MISR_W-1:0]   golden_sig;
  logic [N_CHAINS-1:0] scan_out;
  logic [N_PO-1:0]     po_vec;
  logic                test_mode;
  logic                scan_en;
  logic [N_CHAINS-1:0] scan_in;
  logic [N_PI-1:0]     pi_vec;
  logic                bist_busy;
  logic                bist_end;
  logic                pass_fail;
  logic [MISR_W-1:0]   signature;
  logic [CNT_W-1:0]    pattern_cnt;

  modport master (
    output bist_start, bist_abort, golden_sig, scan_out, po_vec,
    input  test_mode, scan_en, scan_in, pi_vec, bist_busy, bist_end,
           pass_fail, signature, pattern_cnt
  );

  modport slave (
    input  bist_start, bist_abort, golden_sig, scan_out, po_vec,
    output test_mode, scan_en, scan_in, pi_vec, bist_busy, bist_end,
           pass_fail, signature, pattern_cnt
  );
endinterface

// File: rtl/bist_galois_reg.sv
// Galois shift register with load/enable; serves as PRPG (right shift, din=0)
// or MISR (left shift, din = compacted data).
module bist_galois_reg #(
  parameter int           W          = 16,
  parameter logic [W-1:0] POLY       = '0,
  parameter logic [W-1:0] RST_VAL    = '0,
  parameter bit           SHIFT_LEFT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d, q_q, step;

  always_comb begin
    if (SHIFT_LEFT) step = (q_q << 1) ^ (q_q[W-1] ? POLY : '0);
    else            step = (q_q >> 1) ^ (q_q[0]   ? POLY : '0);
    q_d = q_q;
    if (load)    q_d = load_val;
    else if (en) q_d = step ^ din;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= RST_VAL;
    else        q_q <= q_d;

  assign q = q_q;
endmodule

// File: rtl/bist_engine.sv
// Pattern-count driven scan BIST: PRPG feeds chains/PIs, MISR compacts
// unload and POs, final signature compared against a run-time golden value.
module bist_engine
  import bist_pkg::*;
#(
  parameter int                N_CHAINS   = 1,
  parameter int                CHAIN_LEN  = 8,
  parameter int                N_PI       = 3,
  parameter int                N_PO       = 2,
  parameter int                N_PATTERNS = 64,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY  = LFSR_W'(DEF_LFSR_POLY),
  parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_W'(DEF_LFSR_SEED),
  parameter int                MISR_W     = 12,
  parameter logic [MISR_W-1:0] MISR_POLY  = MISR_W'(DEF_MISR_POLY)
) (
  input  logic          CLK,
  input  logic          RST,
  bist_engine_if.slave  bus
);
  localparam int CNT_W = $clog2(N_PATTERNS + 1);
  localparam int SC_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] PAT_LAST = CNT_W'(N_PATTERNS);

  if (LFSR_W < N_CHAINS + N_PI) begin : g_chk_lfsr
    $error("bist_engine: LFSR_W must be >= N_CHAINS+N_PI");
  end
  if (MISR_W < N_CHAINS + N_PO) begin : g_chk_misr
    $error("bist_engine: MISR_W must be >= N_CHAINS+N_PO");
  end
  if (LFSR_SEED == '0) begin : g_chk_seed
    $error("bist_engine: LFSR_SEED must be non-zero");
  end

  bist_state_e       state_d, state_q;
  logic [CNT_W-1:0]  pcnt_d, pcnt_q;
  logic [SC_W-1:0]   sc_d, sc_q;
  logic              pf_d, pf_q;
  logic              busy_d, busy_q, end_d, end_q;
  logic              scan_en_d, scan_en_q, test_mode_d, test_mode_q;
  logic              prpg_load, prpg_en, misr_load, misr_en;
  logic [MISR_W-1:0] misr_din, misr;
  logic [LFSR_W-1:0] lfsr;
  logic              pattern_phase;
  logic              unused_lfsr;

  bist_galois_reg #(.W(LFSR_W), .POLY(LFSR_POLY), .RST_VAL(LFSR_SEED), .SHIFT_LEFT(1'b0)) u_prpg (
    .clk(CLK), .rst_n(RST), .load(prpg_load), .load_val(LFSR_SEED),
    .en(prpg_en), .din('0), .q(lfsr)
  );

  bist_galois_reg #(.W(MISR_W), .POLY(MISR_POLY), .RST_VAL('0), .SHIFT_LEFT(1'b1)) u_misr (
    .clk(CLK), .rst_n(RST), .load(misr_load), .load_val('0),
    .en(misr_en), .din(misr_din), .q(misr)
  );

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    sc_d      = sc_q;
    pf_d      = pf_q;
    prpg_load = 1'b0;
    prpg_en   = 1'b0;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    misr_din  = '0;
    unique case (state_q)
      IDLE: if (bus.bist_start) state_d = SEED;
      SEED: begin
        prpg_load = 1'b1;
        misr_load = 1'b1;
        pcnt_d    = '0;
        sc_d      = '0;
        pf_d      = 1'b0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        prpg_en = 1'b1;
        // the first load has no previous response to unload
        if (pcnt_q != '0) begin
          misr_en  = 1'b1;
          misr_din = MISR_W'(bus.scan_out);
        end
        if (sc_q == SC_LAST) begin
          sc_d    = '0;
          state_d = CAPTURE;
        end else begin
          sc_d = sc_q + 1'b1;
        end
      end
      CAPTURE: begin
        misr_en  = 1'b1;
        misr_din = MISR_W'({bus.po_vec, bus.scan_out});
        pcnt_d   = pcnt_q + 1'b1;
        state_d  = (pcnt_d == PAT_LAST) ? UNLOAD : SHIFT;
      end
      UNLOAD: begin
        misr_en  = 1'b1;
        misr_din = MISR_W'(bus.scan_out);
        if (sc_q == SC_LAST) begin
          sc_d    = '0;
          state_d = COMPARE;
        end else begin
          sc_d = sc_q + 1'b1;
        end
      end
      COMPARE: begin
        pf_d    = (misr == bus.golden_sig);
        state_d = DONE;
      end
      DONE: if (!bus.bist_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.bist_abort) begin
      state_d   = IDLE;
      pcnt_d    = '0;
      sc_d      = '0;
      pf_d      = 1'b0;
      prpg_load = 1'b1;
      prpg_en   = 1'b0;
      misr_load = 1'b1;
      misr_en   = 1'b0;
    end

    busy_d      = !(state_d inside {IDLE, DONE});
    end_d       = (state_d == DONE);
    scan_en_d   = (state_d inside {SHIFT, UNLOAD});
    test_mode_d = (state_d inside {SHIFT, CAPTURE, UNLOAD});
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      pcnt_q      <= '0;
      sc_q        <= '0;
      pf_q        <= 1'b0;
      busy_q      <= 1'b0;
      end_q       <= 1'b0;
      scan_en_q   <= 1'b0;
      test_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      sc_q        <= sc_d;
      pf_q        <= pf_d;
      busy_q      <= busy_d;
      end_q       <= end_d;
      scan_en_q   <= scan_en_d;
      test_mode_q <= test_mode_d;
    end
  end

  // pattern bits only reach the CUT while a pattern is being loaded/applied
  assign pattern_phase   = (state_q == SHIFT) || (state_q == CAPTURE);
  assign bus.scan_in     = pattern_phase ? lfsr[N_CHAINS-1:0] : '0;
  assign bus.pi_vec      = pattern_phase ? lfsr[N_CHAINS +: N_PI] : '0;
  assign bus.test_mode   = test_mode_q;
  assign bus.scan_en     = scan_en_q;
  assign bus.bist_busy   = busy_q;
  assign bus.bist_end    = end_q;
  assign bus.pass_fail   = pf_q;
  assign bus.signature   = misr;
  assign bus.pattern_cnt = pcnt_q;
  assign unused_lfsr     = ^lfsr;
endmodule
